ofm_packer: RTL and testbench

OFM_PACKER -- requirements
Module: ofm_packer

---
 rtl/ofm_packer_pkg.sv | 11 +
 rtl/ofm_beat_fifo.sv | 48 ++++
 rtl/ofm_packer.sv | 77 +++++++
 tb/tb_ofm_packer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_packer_pkg.sv
// ofm_packer_pkg: shared constants, FSM state type and byte-order helper for the OFM packer.
package ofm_packer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NUM_PE_DEF      = 16;
    localparam int BYTE_W          = 8;
    localparam int WORDS_PER_PIXEL = 4;
    localparam int OFM_PIXELS_DEF  = 3136;
    function automatic logic [31:0] byte_rev(logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/ofm_beat_fifo.sv
// ofm_beat_fifo: small beat FIFO; a push into a full FIFO only lands when a pop frees a slot the same cycle.
module ofm_beat_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    function automatic logic [AW-1:0] nxt(logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ofm_packer.sv
// ofm_packer: buffers 16-lane PE beats and streams each as four 32-bit words to the OFM BRAM.
module ofm_packer
    import ofm_packer_pkg::*;
#(
    parameter int NUM_PE     = NUM_PE_DEF,
    parameter int OFM_PIXELS = OFM_PIXELS_DEF,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_W     = 20
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_PE-1:0]        valid_in,
    input  logic [NUM_PE*BYTE_W-1:0] ofm_in,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [31:0]              wr_data,
    input  logic                     wr_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic                     lane_err
);
    localparam int BEAT_W = NUM_PE * BYTE_W;
    localparam int PW     = $clog2(OFM_PIXELS + 1);
    state_t state;
    logic [PW-1:0] pixel_cnt;
    logic [1:0] word_idx;
    logic fifo_empty, fifo_full, beat_ok, push, xfer, pop;
    logic [BEAT_W-1:0] head;
    logic [31:0] addr_full;
    ofm_beat_fifo #(.WIDTH(BEAT_W), .DEPTH(2)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .push  (push),
        .pop   (pop),
        .din   (ofm_in),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );
    assign beat_ok   = &valid_in;
    assign push      = state == RUN && !start && beat_ok;
    assign wr_en     = state == RUN && !fifo_empty;
    assign xfer      = wr_en && wr_ready;
    assign pop       = xfer && word_idx == 2'(WORDS_PER_PIXEL - 1);
    assign addr_full = 32'(BASE_ADDR) + (32'(pixel_cnt) << 2) + 32'(word_idx);
    // Outputs are forced to zero whenever no write is pending so reset and idle look clean.
    assign wr_addr   = wr_en ? addr_full[ADDR_W-1:0] : '0;
    assign wr_data   = wr_en ? byte_rev(head[{word_idx, 5'd0} +: 32]) : '0;
    assign busy      = state == RUN;
    assign done      = state == DONE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pixel_cnt <= '0;
            word_idx  <= '0;
            overflow  <= 1'b0;
            lane_err  <= 1'b0;
        end else if (start) begin
            state     <= RUN;
            pixel_cnt <= '0;
            word_idx  <= '0;
            overflow  <= 1'b0;
            lane_err  <= 1'b0;
        end else if (state == RUN) begin
            if (xfer) word_idx <= word_idx + 2'd1;
            if (pop) begin
                pixel_cnt <= pixel_cnt + PW'(1);
                if (pixel_cnt == PW'(OFM_PIXELS - 1)) state <= DONE;
            end
            if (push && fifo_full && !pop) overflow <= 1'b1;
            if (|valid_in && !beat_ok) lane_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ofm_packer.sv
// tb_ofm_packer: directed and random stimulus against a queue-based reference model of the packer.
module tb_ofm_packer;
    localparam int PIX  = 4;
    localparam int BASE = 100;
    localparam int AW   = 20;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, wr_ready = 1'b0;
    logic [15:0] valid_in = '0;
    logic [127:0] ofm_in = '0;
    logic wr_en, busy, done, overflow, lane_err;
    logic [AW-1:0] wr_addr;
    logic [31:0] wr_data;
    int n_checks = 0, n_fail = 0, n_wr = 0;
    bit running, finished, m_ovf, m_lerr;
    int m_pix, m_word;
    logic [127:0] q[$];

    always #5 clk = ~clk;

    ofm_packer #(.OFM_PIXELS(PIX), .BASE_ADDR(BASE), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .valid_in (valid_in),
        .ofm_in   (ofm_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .lane_err (lane_err)
    );

    // Word w of a beat carries PE 4w..4w+3, lowest-numbered PE in the top byte.
    function automatic logic [31:0] exp_word(logic [127:0] e, int w);
        logic [31:0] d = '0;
        for (int b = 0; b < 4; b++) d = {d[23:0], e[8*(4*w+b) +: 8]};
        return d;
    endfunction

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        running = 0; finished = 0; q.delete();
        m_pix = 0; m_word = 0; m_ovf = 0; m_lerr = 0;
    endtask

    task automatic check_all();
        bit en;
        logic [AW-1:0] ea;
        logic [31:0] ed;
        en = running && q.size() > 0;
        ea = '0;
        ed = '0;
        if (en) begin
            ea = AW'(BASE + 4*m_pix + m_word);
            ed = exp_word(q[0], m_word);
        end
        chk("wr_en", 128'(wr_en), 128'(en));
        chk("wr_addr", 128'(wr_addr), 128'(ea));
        chk("wr_data", 128'(wr_data), 128'(ed));
        chk("busy", 128'(busy), 128'(running));
        chk("done", 128'(done), 128'(finished));
        chk("overflow", 128'(overflow), 128'(m_ovf));
        chk("lane_err", 128'(lane_err), 128'(m_lerr));
    endtask

    task automatic model_step();
        bit en, pop;
        if (start) begin
            reset_model();
            running = 1;
            return;
        end
        if (!running) return;
        en  = q.size() > 0;
        pop = en && wr_ready && m_word == 3;
        if (en && wr_ready) m_word = (m_word + 1) % 4;
        if (valid_in != 16'h0 && valid_in != 16'hFFFF) m_lerr = 1;
        if (pop) begin
            void'(q.pop_front());
            m_pix++;
            if (m_pix == PIX) begin
                running = 0;
                finished = 1;
            end
        end
        if (valid_in == 16'hFFFF) begin
            if (q.size() < 2) q.push_back(ofm_in);
            else m_ovf = 1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        if (wr_en && wr_ready) n_wr++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) cycle();
    endtask

    task automatic beat(logic [127:0] d);
        valid_in = 16'hFFFF;
        ofm_in = d;
        cycle();
        valid_in = '0;
    endtask

    task automatic pulse_start();
        start = 1;
        cycle();
        start = 0;
    endtask

    function automatic logic [127:0] rnd_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] seq, a;
        int w, r;
        for (int k = 0; k < 16; k++) seq[8*k +: 8] = 8'(k + 1);
        reset_model();
        #2;
        check_all();
        idle(2);
        reset = 1;
        idle(2);
        beat(rnd_beat());
        idle(1);

        // single beat, bytes k+1
        pulse_start();
        wr_ready = 1;
        beat(seq);
        chk("sb_w0_data", 128'(wr_data), 128'(32'h01020304));
        chk("sb_w0_addr", 128'(wr_addr), 128'(BASE));
        cycle();
        chk("sb_w1_data", 128'(wr_data), 128'(32'h05060708));
        cycle();
        chk("sb_w2_data", 128'(wr_data), 128'(32'h090A0B0C));
        cycle();
        chk("sb_w3_data", 128'(wr_data), 128'(32'h0D0E0F10));
        chk("sb_w3_addr", 128'(wr_addr), 128'(BASE + 3));
        cycle();
        chk("sb_after_en", 128'(wr_en), 128'(0));

        // backpressure on word 1
        pulse_start();
        beat(seq);
        cycle();
        wr_ready = 0;
        repeat (5) begin
            cycle();
            chk("bp_addr", 128'(wr_addr), 128'(BASE + 1));
            chk("bp_data", 128'(wr_data), 128'(32'h05060708));
        end
        wr_ready = 1;
        w = n_wr;
        idle(5);
        chk("bp_words", 128'(n_wr - w), 128'(3));

        // overflow: third back-to-back beat dropped
        pulse_start();
        wr_ready = 0;
        beat(rnd_beat());
        beat(rnd_beat());
        beat(rnd_beat());
        chk("ovf_flag", 128'(overflow), 128'(1));
        wr_ready = 1;
        w = n_wr;
        idle(12);
        chk("ovf_words", 128'(n_wr - w), 128'(8));

        // partial lane valid
        pulse_start();
        w = n_wr;
        valid_in = 16'h7FFF;
        cycle();
        valid_in = '0;
        chk("lane_err_set", 128'(lane_err), 128'(1));
        idle(3);
        chk("lane_no_write", 128'(n_wr - w), 128'(0));
        pulse_start();
        chk("lane_err_clr", 128'(lane_err), 128'(0));

        // full frame of PIX pixels, then a late beat
        w = n_wr;
        for (int p = 0; p < PIX; p++) begin
            beat(rnd_beat());
            idle(3);
        end
        idle(2);
        chk("frame_done", 128'(done), 128'(1));
        chk("frame_busy", 128'(busy), 128'(0));
        chk("frame_words", 128'(n_wr - w), 128'(16));
        beat(rnd_beat());
        idle(5);
        chk("late_beat_words", 128'(n_wr - w), 128'(16));

        // reset during word 2 of pixel 1
        pulse_start();
        beat(rnd_beat());
        idle(3);
        beat(rnd_beat());
        idle(2);
        chk("rst_pre_addr", 128'(wr_addr), 128'(BASE + 6));
        #2 reset = 0;
        reset_model();
        #1;
        check_all();
        idle(2);
        reset = 1;
        idle(1);
        pulse_start();
        a = rnd_beat();
        beat(a);
        chk("rst_re_addr", 128'(wr_addr), 128'(BASE));
        chk("rst_re_data", 128'(wr_data), 128'(exp_word(a, 0)));

        // random traffic
        repeat (800) begin
            start = $urandom_range(0, 24) == 0;
            r = $urandom_range(0, 9);
            valid_in = r < 6 ? 16'hFFFF : r < 8 ? 16'h0 : 16'($urandom());
            ofm_in = rnd_beat();
            wr_ready = $urandom_range(0, 3) != 0;
            cycle();
        end
        start = 0;
        valid_in = '0;
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
